// File: rtl/ga_in_framer_if.sv
// Sample/desired input bus and tap-vector launch bus between the framer and its neighbours.
interface ga_in_framer_if #(
    parameter int unsigned DATA_W  = 6,
    parameter int unsigned M_MAX   = 32,
    parameter int unsigned M_MAX_W = $clog2(M_MAX + 1)
);
    logic                  i_x_valid;
    logic [DATA_W-1:0]     i_x;
    logic [DATA_W-1:0]     i_d;
    logic [M_MAX_W-1:0]    cnfg_m;
    logic                  i_flush;
    logic                  ga_ready;
    logic                  o_x_ready;
    logic                  o_valid_pls;
    logic [DATA_W-1:0]     o_v_vec [0:M_MAX-1];
    logic [DATA_W-1:0]     o_d;
    logic [15:0]           o_frame_cntr;
    logic [15:0]           o_drop_cntr;

    // Producer / GA-core side.
    modport master (
        output i_x_valid, i_x, i_d, cnfg_m, i_flush, ga_ready,
        input  o_x_ready, o_valid_pls, o_v_vec, o_d, o_frame_cntr, o_drop_cntr
    );

    // Framer side.
    modport slave (
        input  i_x_valid, i_x, i_d, cnfg_m, i_flush, ga_ready,
        output o_x_ready, o_valid_pls, o_v_vec, o_d, o_frame_cntr, o_drop_cntr
    );
endinterface

// File: rtl/ga_in_framer.sv
// Input framer: buffers {x,d} pairs in a small FIFO, builds an m-tap delay line
// and launches one tap vector per pulse to the GA core.
module ga_in_framer #(
    parameter int unsigned DATA_W     = 6,
    parameter int unsigned M_MAX      = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned M_MAX_W    = $clog2(M_MAX + 1)
) (
    input  logic           clk,
    input  logic           rstn,
    ga_in_framer_if.slave  bus
);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned ENT_W  = 2 * DATA_W;
    localparam int unsigned FILL_XW = M_MAX_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_e;

    state_e               state_q;
    logic [ENT_W-1:0]     mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic [DATA_W-1:0]    v_q [M_MAX];
    logic [DATA_W-1:0]    d_q;
    logic [M_MAX_W-1:0]   fill_q;
    logic [M_MAX_W-1:0]   m_q;
    logic                 valid_q;
    logic [15:0]          frame_q;
    logic [15:0]          drop_q;

    logic                 full_c;
    logic                 empty_c;
    logic                 push_c;
    logic                 drop_c;
    logic                 pop_c;
    logic                 warm_c;
    logic [M_MAX_W-1:0]   m_eff_c;
    logic [FILL_XW-1:0]   fill_inc_c;
    logic [ENT_W-1:0]     head_c;

    // FIFO status, clamped tap count and pop decision.
    always_comb begin
        full_c     = (count_q == CNT_W'(FIFO_DEPTH));
        empty_c    = (count_q == CNT_W'(0));
        push_c     = bus.i_x_valid && !full_c && !bus.i_flush;
        drop_c     = bus.i_x_valid &&  full_c && !bus.i_flush;
        m_eff_c    = bus.cnfg_m;
        if (bus.cnfg_m == M_MAX_W'(0)) begin
            m_eff_c = M_MAX_W'(1);
        end else if (bus.cnfg_m > M_MAX_W'(M_MAX)) begin
            m_eff_c = M_MAX_W'(M_MAX);
        end
        // fill < m_eff-1 written as fill+1 < m_eff to avoid underflow
        fill_inc_c = {1'b0, fill_q} + FILL_XW'(1);
        warm_c     = (fill_inc_c < {1'b0, m_eff_c});
        pop_c      = (state_q == IDLE) && !empty_c && !bus.i_flush && (warm_c || bus.ga_ready);
        head_c     = mem_q[rd_ptr_q];
    end

    // FIFO storage; no reset needed since reads are gated by the occupancy count.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= {bus.i_x, bus.i_d};
        end
    end

    // Pointers, delay line, fill, counters and launch FSM.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int k = 0; k < int'(M_MAX); k++) v_q[k] <= '0;
            d_q      <= '0;
            fill_q   <= '0;
            m_q      <= M_MAX_W'(1);
            valid_q  <= 1'b0;
            frame_q  <= '0;
            drop_q   <= '0;
        end else if (bus.i_flush) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int k = 0; k < int'(M_MAX); k++) v_q[k] <= '0;
            d_q      <= '0;
            fill_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push_c) - CNT_W'(pop_c);
            if (drop_c && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
            if (state_q == IDLE) m_q <= m_eff_c;
            if (pop_c) begin
                for (int k = int'(M_MAX) - 1; k > 0; k--) v_q[k] <= v_q[k-1];
                v_q[0] <= head_c[ENT_W-1:DATA_W];
                d_q    <= head_c[DATA_W-1:0];
                if (fill_q != M_MAX_W'(M_MAX)) fill_q <= fill_q + M_MAX_W'(1);
            end
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pop_c && !warm_c) begin
                        state_q <= ISSUE;
                        valid_q <= 1'b1;
                        frame_q <= frame_q + 16'd1;
                    end
                end
                ISSUE: state_q <= HOLD;
                HOLD:  if (!bus.ga_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Taps beyond the active count read as zero.
    always_comb begin
        for (int k = 0; k < int'(M_MAX); k++) begin
            bus.o_v_vec[k] = (M_MAX_W'(k) < m_q) ? v_q[k] : '0;
        end
    end

    assign bus.o_x_ready    = !full_c;
    assign bus.o_valid_pls  = valid_q;
    assign bus.o_d          = d_q;
    assign bus.o_frame_cntr = frame_q;
    assign bus.o_drop_cntr  = drop_q;
endmodule

// File: tb/tb_ga_in_framer.sv
// Scoreboard bench for ga_in_framer: stimulus queues expected launches, a monitor checks each pulse.
module tb_ga_in_framer;
    localparam int unsigned DATA_W     = 6;
    localparam int unsigned M_MAX      = 32;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned M_MAX_W    = $clog2(M_MAX + 1);
    localparam int unsigned VEC_W      = DATA_W * M_MAX;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    ga_in_framer_if #(.DATA_W(DATA_W), .M_MAX(M_MAX), .M_MAX_W(M_MAX_W)) bus ();

    ga_in_framer #(
        .DATA_W(DATA_W), .M_MAX(M_MAX), .FIFO_DEPTH(FIFO_DEPTH), .M_MAX_W(M_MAX_W)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct packed {
        logic [VEC_W-1:0]  vec;
        logic [DATA_W-1:0] d;
        logic [15:0]       frame;
    } exp_t;

    exp_t              sb_q[$];
    exp_t              mon_e;
    logic [DATA_W-1:0] hist[$];
    int                hist_cnt  = 0;
    int                frame_exp = 0;
    int                m_model   = 1;
    int                tests     = 0;
    int                fails     = 0;
    int                pulses    = 0;
    int                p0;

    task automatic check(input string nm, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [VEC_W-1:0] dut_vec();
        logic [VEC_W-1:0] v;
        for (int k = 0; k < int'(M_MAX); k++) v[k*DATA_W +: DATA_W] = bus.o_v_vec[k];
        return v;
    endfunction

    function automatic int clamp_m(input int c);
        if (c == 0) return 1;
        if (c > int'(M_MAX)) return int'(M_MAX);
        return c;
    endfunction

    // Reference: accepted samples in arrival order; a launch is due once m samples exist.
    task automatic model_accept(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] d);
        exp_t e;
        hist.push_front(x);
        if (hist.size() > int'(M_MAX)) void'(hist.pop_back());
        hist_cnt++;
        if (hist_cnt >= m_model) begin
            e.vec = '0;
            for (int k = 0; k < m_model; k++) e.vec[k*DATA_W +: DATA_W] = hist[k];
            frame_exp++;
            e.d     = d;
            e.frame = 16'(frame_exp);
            sb_q.push_back(e);
        end
    endtask

    task automatic model_flush();
        hist.delete();
        hist_cnt = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 accepted, 1 dropped (FIFO full), 2 stored but later flushed.
    task automatic push(input int x, input int d, input int kind);
        bus.i_x       = DATA_W'(x);
        bus.i_d       = DATA_W'(d);
        bus.i_x_valid = 1'b1;
        check("x_ready_at_push", VEC_W'(bus.o_x_ready), VEC_W'(kind == 1 ? 0 : 1));
        tick();
        bus.i_x_valid = 1'b0;
        if (kind == 0) model_accept(DATA_W'(x), DATA_W'(d));
    endtask

    task automatic wait_pulse(input string nm, input int budget);
        int start;
        int n;
        start = pulses;
        n = 0;
        while (pulses == start && n < budget) begin
            tick();
            n++;
        end
        check(nm, VEC_W'(pulses != start), VEC_W'(1));
    endtask

    // GA core accepts one vector, then drops ready so HOLD returns to IDLE.
    task automatic release_one(input string nm);
        bus.ga_ready = 1'b1;
        wait_pulse(nm, 10);
        bus.ga_ready = 1'b0;
        tick();
    endtask

    // Monitor: every launch pulse must match the oldest expected vector.
    always @(negedge clk) begin
        if (rstn === 1'b1 && bus.o_valid_pls === 1'b1) begin
            pulses++;
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pulse: got pulse with frame %0d, expected none", bus.o_frame_cntr);
            end else begin
                mon_e = sb_q.pop_front();
                check("pulse_vec",   dut_vec(), mon_e.vec);
                check("pulse_d",     VEC_W'(bus.o_d), VEC_W'(mon_e.d));
                check("pulse_frame", VEC_W'(bus.o_frame_cntr), VEC_W'(mon_e.frame));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_x_valid = 1'b0;
        bus.i_x       = '0;
        bus.i_d       = '0;
        bus.cnfg_m    = '0;
        bus.i_flush   = 1'b0;
        bus.ga_ready  = 1'b0;
        rstn          = 1'b1;
        #1 rstn = 1'b0;

        // Reset state
        #7;
        check("rst_valid",  VEC_W'(bus.o_valid_pls), VEC_W'(0));
        check("rst_ready",  VEC_W'(bus.o_x_ready), VEC_W'(1));
        check("rst_vec",    dut_vec(), VEC_W'(0));
        check("rst_frame",  VEC_W'(bus.o_frame_cntr), VEC_W'(0));
        check("rst_drop",   VEC_W'(bus.o_drop_cntr), VEC_W'(0));
        #4 rstn = 1'b1;

        // Warm-up with m=7
        bus.cnfg_m   = M_MAX_W'(7);
        m_model      = clamp_m(7);
        bus.ga_ready = 1'b1;
        tick();
        for (int x = 1; x <= 7; x++) push(x, (x == 7) ? 28 : 10 + x, 0);
        @(negedge clk);
        check("lat_pop_edge", VEC_W'(bus.o_valid_pls), VEC_W'(0));
        @(negedge clk);
        check("lat_pulse",    VEC_W'(bus.o_valid_pls), VEC_W'(1));
        check("warm_tap0",    VEC_W'(bus.o_v_vec[0]), VEC_W'(7));
        check("warm_tap6",    VEC_W'(bus.o_v_vec[6]), VEC_W'(1));
        check("warm_tap7",    VEC_W'(bus.o_v_vec[7]), VEC_W'(0));
        check("warm_d",       VEC_W'(bus.o_d), VEC_W'(28));
        check("warm_frame",   VEC_W'(bus.o_frame_cntr), VEC_W'(1));
        @(negedge clk);
        check("pulse_width",  VEC_W'(bus.o_valid_pls), VEC_W'(0));

        // HOLD: ready held high never re-launches
        push(8, 5, 0);
        p0 = pulses;
        repeat (20) tick();
        check("hold_no_repulse", VEC_W'(pulses), VEC_W'(p0));
        bus.ga_ready = 1'b0;
        tick();
        bus.ga_ready = 1'b1;
        wait_pulse("hold_release", 10);
        bus.ga_ready = 1'b0;
        tick();

        // Backpressure: four stored, fifth dropped
        for (int x = 9; x <= 12; x++) push(x, x + 20, 0);
        push(13, 33, 1);
        check("bp_ready_low", VEC_W'(bus.o_x_ready), VEC_W'(0));
        check("bp_drop_cntr", VEC_W'(bus.o_drop_cntr), VEC_W'(1));
        p0 = pulses;
        repeat (3) tick();
        check("bp_no_pulse", VEC_W'(pulses), VEC_W'(p0));
        repeat (4) release_one("bp_release");

        // Flush in HOLD with three queued entries plus a same-cycle push
        push(14, 7, 0);
        bus.ga_ready = 1'b1;
        wait_pulse("pre_flush", 10);
        push(20, 1, 2);
        push(21, 2, 2);
        push(22, 3, 2);
        bus.i_flush   = 1'b1;
        bus.i_x_valid = 1'b1;
        bus.i_x       = DATA_W'(23);
        tick();
        bus.i_flush   = 1'b0;
        bus.i_x_valid = 1'b0;
        model_flush();
        check("flush_vec",   dut_vec(), VEC_W'(0));
        check("flush_d",     VEC_W'(bus.o_d), VEC_W'(0));
        check("flush_frame", VEC_W'(bus.o_frame_cntr), VEC_W'(7));
        check("flush_drop",  VEC_W'(bus.o_drop_cntr), VEC_W'(1));
        repeat (3) tick();
        check("flush_fifo_empty", dut_vec(), VEC_W'(0));
        for (int x = 31; x <= 37; x++) push(x, x + 1, 0);
        wait_pulse("flush_refill", 10);
        bus.ga_ready = 1'b0;
        tick();

        // cnfg_m = 0 behaves as one tap
        bus.i_flush = 1'b1;
        tick();
        bus.i_flush = 1'b0;
        model_flush();
        bus.cnfg_m = M_MAX_W'(0);
        m_model    = clamp_m(0);
        tick();
        push(3, 11, 0);  release_one("m0_a");
        push(40, 22, 0); release_one("m0_b");
        push(63, 33, 0); release_one("m0_c");

        // cnfg_m = 40 clamps to 32 taps
        bus.i_flush = 1'b1;
        tick();
        bus.i_flush = 1'b0;
        model_flush();
        bus.cnfg_m   = M_MAX_W'(40);
        m_model      = clamp_m(40);
        tick();
        bus.ga_ready = 1'b1;
        for (int x = 1; x <= 31; x++) push(x, x, 0);
        p0 = pulses;
        repeat (3) tick();
        check("clamp_no_early", VEC_W'(pulses), VEC_W'(p0));
        push(32, 50, 0);
        wait_pulse("clamp_first", 10);

        // Asynchronous reset while ISSUE is active
        bus.ga_ready = 1'b0;
        tick();
        push(33, 2, 0);
        bus.ga_ready = 1'b1;
        p0 = pulses;
        for (int i = 0; i < 20 && pulses == p0; i++) begin
            @(negedge clk);
            #1;
        end
        check("rst_mid_seen",  VEC_W'(bus.o_valid_pls), VEC_W'(1));
        rstn = 1'b0;
        #1;
        check("rst_mid_valid", VEC_W'(bus.o_valid_pls), VEC_W'(0));
        check("rst_mid_ready", VEC_W'(bus.o_x_ready), VEC_W'(1));
        check("rst_mid_vec",   dut_vec(), VEC_W'(0));
        check("rst_mid_d",     VEC_W'(bus.o_d), VEC_W'(0));
        check("rst_mid_frame", VEC_W'(bus.o_frame_cntr), VEC_W'(0));
        check("rst_mid_drop",  VEC_W'(bus.o_drop_cntr), VEC_W'(0));
        sb_q.delete();
        model_flush();
        frame_exp  = 0;
        bus.cnfg_m = M_MAX_W'(0);
        m_model    = clamp_m(0);
        @(negedge clk);
        rstn = 1'b1;
        push(9, 4, 0);
        wait_pulse("post_rst_first", 10);

        repeat (3) tick();
        check("sb_drained", VEC_W'(sb_q.size()), VEC_W'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
